// File: rtl/turn_timer.sv
// Turn timer: prescaled seconds countdown that reports a finished turn to the
// game-turn controller and distinguishes an expired turn from a committed move.
//
// state | meaning
// IDLE  | waiting for a rising edge on info
// COUNT | countdown active, accepting player moves
// DONE  | turn finished; waits for info and alu_turn to drop
module turn_timer #(
  parameter int unsigned TICK_DIV     = 50000000,
  parameter int unsigned TURN_SECONDS = 15
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       info_i,
  input  logic       alu_turn_i,
  input  logic       move_valid_i,
  output logic       turn_done_o,
  output logic       timeout_o,
  output logic       move_reject_o,
  output logic       running_o,
  output logic [6:0] secs_left_o,
  output logic [3:0] secs_tens_o,
  output logic [3:0] secs_ones_o
);

  localparam int PW = $clog2(TICK_DIV);

  typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [6:0]    secs_q, secs_d;
  logic          info_q;
  logic          turn_done_q, turn_done_d;
  logic          timeout_q, timeout_d;
  logic          move_reject_q, move_reject_d;
  logic          start;
  logic          tick;

  assign start = info_i & ~info_q;
  assign tick  = (presc_q == PW'(TICK_DIV - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      presc_q       <= '0;
      secs_q        <= '0;
      info_q        <= 1'b0;
      turn_done_q   <= 1'b0;
      timeout_q     <= 1'b0;
      move_reject_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      presc_q       <= presc_d;
      secs_q        <= secs_d;
      info_q        <= info_i;
      turn_done_q   <= turn_done_d;
      timeout_q     <= timeout_d;
      move_reject_q <= move_reject_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    presc_d       = presc_q;
    secs_d        = secs_q;
    turn_done_d   = 1'b0;
    timeout_d     = timeout_q;
    move_reject_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        move_reject_d = move_valid_i;
        if (start) begin
          state_d = COUNT;
          secs_d  = 7'(TURN_SECONDS);
          presc_d = '0;
        end
      end
      COUNT: begin
        move_reject_d = move_valid_i & ~alu_turn_i;
        if (start) begin
          secs_d  = 7'(TURN_SECONDS);
          presc_d = '0;
        end else if (move_valid_i && alu_turn_i) begin
          // A move beats a simultaneous final tick, so secs_left is not decremented.
          state_d     = DONE;
          turn_done_d = 1'b1;
          timeout_d   = 1'b0;
        end else begin
          presc_d = tick ? '0 : presc_q + PW'(1);
          if (tick && secs_q != 7'd0) begin
            secs_d = secs_q - 7'd1;
            if (secs_q == 7'd1) begin
              state_d     = DONE;
              turn_done_d = 1'b1;
              timeout_d   = 1'b1;
            end
          end
        end
      end
      DONE: begin
        move_reject_d = move_valid_i;
        if (!info_i && !alu_turn_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign turn_done_o   = turn_done_q;
  assign timeout_o     = timeout_q;
  assign move_reject_o = move_reject_q;
  assign running_o     = (state_q == COUNT);
  assign secs_left_o   = secs_q;
  assign secs_tens_o   = 4'(secs_q / 7'd10);
  assign secs_ones_o   = 4'(secs_q % 7'd10);

endmodule
